// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, MSB first.
// The dividend shift register doubles as the quotient accumulator as its bits are consumed.
module seq_divider #(
    parameter int size = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [size-1:0] dividend,
    input  logic [size-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [size-1:0] quotient,
    output logic [size-1:0] remainder,
    output logic            div_by_zero
);

    localparam int cw = $clog2(size + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [size-1:0] shift_reg, shift_nx;
    logic [size-1:0] divisor_reg, divisor_nx;
    logic [size-1:0] part_rem, part_rem_nx;
    logic [size-1:0] quotient_nx, remainder_nx;
    logic [size-1:0] diff;
    logic [size:0]   trial;
    logic [cw-1:0]   count, count_nx;
    logic            dbz_nx;
    logic            q_bit;

    // The partial remainder is always below the divisor, so size bits hold it
    // between steps; only the shifted trial value needs the extra bit.
    always_comb begin
        trial = {part_rem, shift_reg[size-1]};
        q_bit = (trial >= {1'b0, divisor_reg});
        diff  = trial[size-1:0] - divisor_reg;
    end

    always_comb begin
        state_nx     = state;
        shift_nx     = shift_reg;
        divisor_nx   = divisor_reg;
        part_rem_nx  = part_rem;
        count_nx     = count;
        quotient_nx  = quotient;
        remainder_nx = remainder;
        dbz_nx       = div_by_zero;
        case (state)
            IDLE, DONE: begin
                state_nx = IDLE;
                if (start) begin
                    shift_nx    = dividend;
                    divisor_nx  = divisor;
                    part_rem_nx = '0;
                    count_nx    = '0;
                    if (divisor == '0) begin
                        state_nx     = DONE;
                        quotient_nx  = '1;
                        remainder_nx = dividend;
                        dbz_nx       = 1'b1;
                    end else begin
                        state_nx = RUN;
                    end
                end
            end
            RUN: begin
                shift_nx    = {shift_reg[size-2:0], q_bit};
                part_rem_nx = q_bit ? diff : trial[size-1:0];
                count_nx    = count + cw'(1);
                if (count == cw'(size - 1)) begin
                    state_nx     = DONE;
                    quotient_nx  = {shift_reg[size-2:0], q_bit};
                    remainder_nx = part_rem_nx;
                    dbz_nx       = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shift_reg   <= '0;
            divisor_reg <= '0;
            part_rem    <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_nx;
            shift_reg   <= shift_nx;
            divisor_reg <= divisor_nx;
            part_rem    <= part_rem_nx;
            count       <= count_nx;
            quotient    <= quotient_nx;
            remainder   <= remainder_nx;
            div_by_zero <= dbz_nx;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: arithmetic reference model compared every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_seq_divider;
    localparam int size = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [size-1:0] dividend = '0;
    logic [size-1:0] divisor = '0;
    logic            busy, done, div_by_zero;
    logic [size-1:0] quotient, remainder;

    int checks = 0;
    int errors = 0;

    seq_divider #(.size(size)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference model: tracks acceptance and completion by cycle count, results by / and %.
    bit m_busy = 0, m_done = 0, m_dbz = 0, armed = 0;
    int m_q = 0, m_r = 0, p_q = 0, p_r = 0, done_at = 0, cyc = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_dbz = 0; m_q = 0; m_r = 0;
            armed  = 1;
        end else begin
            cyc++;
            m_done = 0;
            if (m_busy) begin
                if (cyc == done_at) begin
                    m_q = p_q; m_r = p_r; m_dbz = 0;
                    m_busy = 0; m_done = 1;
                end
            end else if (start) begin
                if (divisor == 0) begin
                    m_q = 65535; m_r = int'(dividend); m_dbz = 1; m_done = 1;
                end else begin
                    p_q = int'(dividend) / int'(divisor);
                    p_r = int'(dividend) % int'(divisor);
                    done_at = cyc + size;
                    m_busy = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("cyc_busy", 32'(busy), 32'(m_busy));
            check("cyc_done", 32'(done), 32'(m_done));
            check("cyc_quotient", 32'(quotient), 32'(m_q));
            check("cyc_remainder", 32'(remainder), 32'(m_r));
            check("cyc_div_by_zero", 32'(div_by_zero), 32'(m_dbz));
        end
    end

    // Called at posedge+1 after the accepting edge; n counts edges after the accept.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (done !== 1'b1) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done, want done within 40 cycles");
        end
    endtask

    task automatic launch(input int a, input int b);
        start = 1'b1; dividend = 16'(a); divisor = 16'(b);
        @(posedge clk); #1;
        start = 1'b0;
        dividend = 16'($urandom); divisor = 16'($urandom);
    endtask

    task automatic run_op(input int a, input int b, input int wq, input int wr, input int wz,
                          input int wlat);
        int n;
        launch(a, b);
        wait_done(n);
        check("latency", 32'(n), 32'(wlat));
        check("quotient", 32'(quotient), 32'(wq));
        check("remainder", 32'(remainder), 32'(wr));
        check("div_by_zero", 32'(div_by_zero), 32'(wz));
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int n, a, b, prod, dcount;
        int pa[4] = '{25, 84, 125, 43};
        int pb[4] = '{64, 66, 641, 604};

        #3 rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        #8 rst = 1'b0;
        @(posedge clk); #1;

        run_op(150, 15, 10, 0, 0, 16);

        for (int i = 0; i < 4; i++) begin
            a = pa[i]; b = pb[i];
            prod = (a * b) & 32'hFFFF;
            launch(prod, b);
            wait_done(n);
            check("rt_latency", 32'(n), 32'd16);
            check("rt_invariant", 32'(quotient) * 32'(b) + 32'(remainder), 32'(prod));
            check("rt_rem_lt_b", 32'(remainder < 16'(b)), 32'd1);
            if (a * b < 65536) begin
                check("rt_quotient", 32'(quotient), 32'(a));
                check("rt_remainder", 32'(remainder), 32'd0);
            end
            @(posedge clk); #1;
        end

        run_op(65535, 1, 65535, 0, 0, 16);
        run_op(5, 7, 0, 5, 0, 16);
        run_op(65535, 65535, 1, 0, 0, 16);
        run_op(43, 0, 65535, 43, 1, 0);

        // start held high across two operations; the second is taken in the first's DONE cycle
        start = 1'b1; dividend = 16'd100; divisor = 16'd7;
        @(posedge clk); #1;
        dividend = 16'd200; divisor = 16'd9;
        check("b2b_busy_first", 32'(busy), 32'd1);
        wait_done(n);
        check("b2b_lat_first", 32'(n), 32'd16);
        check("b2b_q_first", 32'(quotient), 32'd14);
        check("b2b_r_first", 32'(remainder), 32'd2);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_busy_second", 32'(busy), 32'd1);
        check("b2b_q_held", 32'(quotient), 32'd14);
        wait_done(n);
        check("b2b_lat_second", 32'(n), 32'd16);
        check("b2b_q_second", 32'(quotient), 32'd22);
        check("b2b_r_second", 32'(remainder), 32'd2);
        @(posedge clk); #1;

        // reset in the middle of a running operation
        launch(1000, 3);
        repeat (7) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_quotient", 32'(quotient), 32'd0);
        check("abort_remainder", 32'(remainder), 32'd0);
        #2 rst = 1'b0;
        dcount = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done === 1'b1) dcount++;
        end
        check("abort_no_done", 32'(dcount), 32'd0);
        run_op(1000, 3, 333, 1, 0, 16);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, want finish before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
